// File: rtl/health_tracker_pkg.sv
// Shared game-logic types and constants for the player health path.
// The HUD renderer reuses HEALTH_W and HEALTH_MAX_DEFAULT for its bar compares.
package health_tracker_pkg;

  localparam int HEALTH_MAX_DEFAULT = 3;
  localparam int HEALTH_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALIVE,
    ST_INVULN,
    ST_DEAD
  } health_state_t;

  function automatic logic [HEALTH_W-1:0] health_inc_sat(
    input logic [HEALTH_W-1:0] h,
    input logic [HEALTH_W-1:0] max_h
  );
    return (h >= max_h) ? max_h : h + HEALTH_W'(1);
  endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Loadable down-counter stepped by the frame tick; flags the final count
// so the owner can act on the tick that takes it to zero.
module frame_down_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         last
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == W'(1));

endmodule

// File: rtl/health_tracker.sv
// Player health FSM: owns present_health for the HUD, runs the post-hit
// invulnerability window with sprite blink, and raises game_over.
//
// state     | meaning
// ST_IDLE   | no game running, health 0, events other than start ignored
// ST_ALIVE  | game running, player can be damaged
// ST_INVULN | post-hit window, hits ignored, frame ticks count down
// ST_DEAD   | health exhausted, waits for start
module health_tracker
  import health_tracker_pkg::*;
#(
  parameter int MAX_HEALTH    = HEALTH_MAX_DEFAULT,
  parameter int START_HEALTH  = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_PERIOD  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic                start,
  input  logic                hit,
  input  logic                heal,
  output logic [HEALTH_W-1:0] present_health,
  output logic                invincible,
  output logic                blink,
  output logic                game_over
);

  localparam int CNT_W     = $clog2(INVULN_FRAMES + 1);
  localparam int BLINK_BIT = $clog2(BLINK_PERIOD);

  localparam logic [HEALTH_W-1:0] MAX_H      = HEALTH_W'(MAX_HEALTH);
  localparam logic [HEALTH_W-1:0] START_H    = HEALTH_W'(START_HEALTH);
  localparam logic [CNT_W-1:0]    INV_LOAD   = CNT_W'(INVULN_FRAMES);
  // Zero when the blink bit lies above the counter, so blink simply never fires.
  localparam logic [CNT_W-1:0]    BLINK_MASK = CNT_W'(64'd1 << BLINK_BIT);

  health_state_t       state_q, state_d;
  logic [HEALTH_W-1:0] health_q, health_d;
  logic [HEALTH_W-1:0] health_dec;
  logic                invincible_q, invincible_d;
  logic                game_over_q, game_over_d;
  logic                cnt_clear, cnt_load, cnt_en, cnt_last;
  logic [CNT_W-1:0]    cnt;

  frame_down_counter #(.W(CNT_W)) u_inv_cnt (
    .clk      (clk),
    .rst_n    (rst),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_val (INV_LOAD),
    .en       (cnt_en),
    .count    (cnt),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      health_q     <= '0;
      invincible_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      health_q     <= health_d;
      invincible_q <= invincible_d;
      game_over_q  <= game_over_d;
    end
  end

  assign health_dec = health_q - HEALTH_W'(1);

  always_comb begin
    state_d   = state_q;
    health_d  = health_q;
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    if (start) begin
      state_d   = ST_ALIVE;
      health_d  = START_H;
      cnt_clear = 1'b1;
    end else begin
      unique case (state_q)
        ST_ALIVE: begin
          if (hit) begin
            health_d = health_dec;
            if (health_dec == '0) begin
              state_d = ST_DEAD;
            end else begin
              state_d  = ST_INVULN;
              cnt_load = 1'b1;
            end
          end else if (heal) begin
            health_d = health_inc_sat(health_q, MAX_H);
          end
        end
        ST_INVULN: begin
          if (heal) begin
            health_d = health_inc_sat(health_q, MAX_H);
          end
          if (frame_tick) begin
            cnt_en = 1'b1;
            if (cnt_last) begin
              state_d = ST_ALIVE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    invincible_d = (state_d == ST_INVULN);
    game_over_d  = (state_d == ST_DEAD);
  end

  assign present_health = health_q;
  assign invincible     = invincible_q;
  assign game_over      = game_over_q;
  // Both operands are flop outputs, so blink still changes only on the clock edge.
  assign blink          = invincible_q & (|(cnt & BLINK_MASK));

endmodule

// File: tb/tb_health_tracker.sv
// Self-checking bench for health_tracker: directed scenarios plus a random
// soak, all compared against a rule-level model of the player's health.
module tb_health_tracker;

  localparam int MAXH  = 3;
  localparam int STRTH = 3;
  localparam int INVF  = 60;
  localparam int BP    = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic       heal = 1'b0;
  logic [3:0] present_health;
  logic       invincible;
  logic       blink;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  // Model: phase 0=idle 1=alive 2=invulnerable 3=dead
  int m_phase  = 0;
  int m_health = 0;
  int m_frames = 0;

  health_tracker #(
    .MAX_HEALTH(MAXH), .START_HEALTH(STRTH), .INVULN_FRAMES(INVF), .BLINK_PERIOD(BP)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .hit(hit),
    .heal(heal), .present_health(present_health), .invincible(invincible),
    .blink(blink), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic int heal_one(input int h);
    return (h < MAXH) ? h + 1 : MAXH;
  endfunction

  function automatic logic exp_blink();
    return (m_phase == 2) && (((m_frames / BP) % 2) == 1);
  endfunction

  task automatic model_event(input logic s, input logic h, input logic he, input logic t);
    if (s) begin
      m_phase = 1; m_health = STRTH; m_frames = 0;
    end else if (m_phase == 1) begin
      if (h) begin
        m_health = m_health - 1;
        if (m_health == 0) m_phase = 3;
        else begin m_phase = 2; m_frames = INVF; end
      end else if (he) begin
        m_health = heal_one(m_health);
      end
    end else if (m_phase == 2) begin
      if (he) m_health = heal_one(m_health);
      if (t) begin
        m_frames = m_frames - 1;
        if (m_frames == 0) m_phase = 1;
      end
    end
  endtask

  task automatic step(input logic s, input logic h, input logic he, input logic t);
    start = s; hit = h; heal = he; frame_tick = t;
    @(posedge clk);
    model_event(s, h, he, t);
    #1;
    start = 1'b0; hit = 1'b0; heal = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    checks++; if (present_health !== 4'd0) begin errors++; $display("FAIL reset_health: got %0d want 0", present_health); end
    checks++; if (invincible !== 1'b0) begin errors++; $display("FAIL reset_invincible: got %b want 0", invincible); end
    checks++; if (blink !== 1'b0) begin errors++; $display("FAIL reset_blink: got %b want 0", blink); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %b want 0", game_over); end
    @(posedge clk); #1;
    step(1'b0, 1'b1, 1'b1, 1'b1);
    checks++; if (present_health !== 4'd0 || invincible !== 1'b0) begin errors++; $display("FAIL idle_ignore: got h=%0d inv=%b want h=0 inv=0", present_health, invincible); end
  endtask

  task automatic test_start();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (present_health !== 4'd3) begin errors++; $display("FAIL start_health: got %0d want 3", present_health); end
    checks++; if (game_over !== 1'b0 || invincible !== 1'b0) begin errors++; $display("FAIL start_flags: got go=%b inv=%b want 0 0", game_over, invincible); end
  endtask

  task automatic test_hit_invuln();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (present_health !== 4'd2 || invincible !== 1'b1) begin errors++; $display("FAIL hit_enter: got h=%0d inv=%b want h=2 inv=1", present_health, invincible); end
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (present_health !== 4'd2) begin errors++; $display("FAIL hit_during_invuln: got %0d want 2", present_health); end
    run_ticks(59);
    checks++; if (invincible !== 1'b1) begin errors++; $display("FAIL invuln_59_ticks: got %b want 1", invincible); end
    run_ticks(1);
    checks++; if (invincible !== 1'b0) begin errors++; $display("FAIL invuln_60_ticks: got %b want 0", invincible); end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (present_health !== 4'd1 || invincible !== 1'b1) begin errors++; $display("FAIL hit_after_window: got h=%0d inv=%b want h=1 inv=1", present_health, invincible); end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (present_health !== 4'd2) begin errors++; $display("FAIL heal_in_invuln: got %0d want 2", present_health); end
    run_ticks(60);
  endtask

  task automatic test_hit_heal_same();
    step(1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (present_health !== 4'd1 || invincible !== 1'b1) begin errors++; $display("FAIL hit_heal_same: got h=%0d inv=%b want h=1 inv=1", present_health, invincible); end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (present_health !== 4'd3) begin errors++; $display("FAIL heal_saturate: got %0d want 3", present_health); end
    run_ticks(60);
    checks++; if (invincible !== 1'b0) begin errors++; $display("FAIL heal_no_extend: got %b want 0", invincible); end
  endtask

  task automatic test_death();
    step(1'b0, 1'b1, 1'b0, 1'b0); run_ticks(60);
    step(1'b0, 1'b1, 1'b0, 1'b0); run_ticks(60);
    checks++; if (present_health !== 4'd1) begin errors++; $display("FAIL pre_death_health: got %0d want 1", present_health); end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (present_health !== 4'd0 || game_over !== 1'b1 || invincible !== 1'b0) begin errors++; $display("FAIL death: got h=%0d go=%b inv=%b want 0 1 0", present_health, game_over, invincible); end
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (present_health !== 4'd0 || game_over !== 1'b1) begin errors++; $display("FAIL dead_ignore: got h=%0d go=%b want 0 1", present_health, game_over); end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (present_health !== 4'd3 || game_over !== 1'b0) begin errors++; $display("FAIL restart: got h=%0d go=%b want 3 0", present_health, game_over); end
  endtask

  task automatic test_blink();
    step(1'b0, 1'b1, 1'b0, 1'b1);
    checks++; if (blink !== 1'b1) begin errors++; $display("FAIL blink_at_60: got %b want 1", blink); end
    for (int k = INVF; k >= 1; k--) begin
      checks++; if (invincible !== 1'b1 || blink !== exp_blink()) begin errors++; $display("FAIL blink_count_%0d: got inv=%b blink=%b want 1 %b", k, invincible, blink, exp_blink()); end
      if (k == 55) begin
        checks++; if (blink !== 1'b0) begin errors++; $display("FAIL blink_at_55: got %b want 0", blink); end
      end
      if ((k % 7) == 0) step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    checks++; if (invincible !== 1'b0 || blink !== 1'b0) begin errors++; $display("FAIL blink_end: got inv=%b blink=%b want 0 0", invincible, blink); end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (present_health !== 4'd3 || invincible !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL start_over_hit: got h=%0d inv=%b go=%b want 3 0 0", present_health, invincible, game_over); end
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(3);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    checks++; if (present_health !== 4'd0 || invincible !== 1'b0 || blink !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL async_reset: got h=%0d inv=%b blink=%b go=%b want all 0", present_health, invincible, blink, game_over); end
    m_phase = 0; m_health = 0; m_frames = 0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 1'b1, 1'b1, 1'b1);
    checks++; if (present_health !== 4'd0 || invincible !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got h=%0d inv=%b go=%b want 0 0 0", present_health, invincible, game_over); end
  endtask

  task automatic test_random();
    logic s, h, he, t;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      s  = ($urandom_range(0, 199) == 0);
      h  = ($urandom_range(0, 7) == 0);
      he = ($urandom_range(0, 7) == 0);
      t  = ($urandom_range(0, 2) == 0);
      step(s, h, he, t);
      checks++; if (present_health !== 4'(m_health)) begin errors++; $display("FAIL rand_health cyc %0d: got %0d want %0d", i, present_health, m_health); end
      checks++; if (invincible !== (m_phase == 2)) begin errors++; $display("FAIL rand_invincible cyc %0d: got %b want %b", i, invincible, (m_phase == 2)); end
      checks++; if (blink !== exp_blink()) begin errors++; $display("FAIL rand_blink cyc %0d: got %b want %b", i, blink, exp_blink()); end
      checks++; if (game_over !== (m_phase == 3)) begin errors++; $display("FAIL rand_game_over cyc %0d: got %b want %b", i, game_over, (m_phase == 3)); end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hit_invuln();
    test_hit_heal_same();
    test_death();
    test_blink();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/health_tracker.md
# health_tracker

Player health state machine that owns `present_health` for the HUD health-bar renderer; it is the writer side of the health value the display path reads. It takes single-cycle game events (start, hit, heal) and a once-per-frame tick, and maintains the health count, a post-hit invulnerability window with sprite blink, and the game-over flag. It sits in the game-logic layer between the collision/pickup detectors and the VGA overlay logic.

## Interface
- `MAX_HEALTH`, default 3: health ceiling. Range 1..15.
- `START_HEALTH`, default 3: health loaded on start. Range 1..MAX_HEALTH.
- `INVULN_FRAMES`, default 60: frames of invulnerability after a non-fatal hit. Must be ≥ 1.
- `BLINK_PERIOD`, default 8: frames per blink half-period. Power of two.
- `clk` in 1: system clock (pixel-clock domain).
- `rst` in 1: reset, asynchronous, active-low.
- `frame_tick` in 1: one-cycle pulse per video frame (vsync start).
- `start` in 1: one-cycle pulse that starts or restarts a game.
- `hit` in 1: one-cycle pulse when the player is damaged.
- `heal` in 1: one-cycle pulse when a health pickup is collected.
- `present_health` out 4: current health, 0..MAX_HEALTH.
- `invincible` out 1: high while in INVULN.
- `blink` out 1: sprite-hide strobe during invulnerability.
- `game_over` out 1: high in DEAD.

## Operation
- States: IDLE, ALIVE, INVULN, DEAD. Reset → IDLE.
- Event priority, every state: `start` > `hit` > `heal`. Lower-priority events in the same cycle are discarded, not queued.
- `start`, any state → ALIVE, `present_health`=START_HEALTH, invulnerability counter cleared, `game_over`=0.
- IDLE: `present_health`=0. `hit`/`heal`/`frame_tick` ignored.
- ALIVE, `hit`: health−1. If the result is 0 → DEAD. Otherwise → INVULN with counter=INVULN_FRAMES.
- ALIVE, `heal`: health+1, saturating at MAX_HEALTH. State unchanged.
- INVULN: `hit` ignored. `heal` is applied as in ALIVE and the counter is unaffected. Each `frame_tick` decrements the counter. A tick arriving while counter==1 → ALIVE with counter=0.
- `frame_tick` coincident with a `hit` that enters INVULN: the counter loads INVULN_FRAMES and the tick is not counted.
- DEAD: `present_health`=0, `game_over`=1. `hit`/`heal` ignored. Leaves DEAD only on `start`.
- `invincible` = (state==INVULN).
- `blink` = `invincible` AND bit log2(BLINK_PERIOD) of the counter is 1.
- Counter width is $clog2(INVULN_FRAMES+1). Health arithmetic is 4-bit unsigned. Underflow and overflow are impossible by construction, and health below 0 is never stored.

## Timing
- All outputs are registered. Each output reflects an input event on the clock edge that samples it, so it is visible the next cycle: 1-cycle latency.
- Reset values: `present_health`=0, `invincible`=0, `blink`=0, `game_over`=0, counter=0.
- Asynchronous assertion of `rst` mid-game forces all of the above immediately. Deassertion is synchronous to `clk` (externally synchronized).
- Inputs are single-cycle pulses synchronous to `clk`. A pulse held high for N cycles counts as N events.
- Invulnerability duration is exactly INVULN_FRAMES `frame_tick` pulses after the hit cycle.

## Structure
- Shared game package holds:
  - the state enum type `health_state_t`;
  - default constants `HEALTH_MAX_DEFAULT`=3 and `HEALTH_W`=4, which the HUD renderer also uses for its bar comparisons.
- One sub-module, `frame_down_counter`:
  - loadable down-counter, parameterized width;
  - enabled by `frame_tick`;
  - outputs `count` and a `last` flag (count==1).
- The FSM and health register live in `health_tracker`.

## Test plan
- Reset then `start` → next cycle `present_health`=3, `game_over`=0, `invincible`=0.
- ALIVE at health 3, `hit` → health 2, `invincible`=1. A second `hit` 5 cycles later leaves health at 2. After 60 `frame_tick`s, `invincible`=0, and the next `hit` gives health 1.
- Health 2, `hit` and `heal` in the same cycle → health 1 and INVULN (heal dropped). `heal` at health 3 stays 3.
- Health 1, `hit` → health 0, `game_over`=1. Later `hit`/`heal` change nothing. `start` → health 3, `game_over`=0.
- During INVULN, check `blink` against counter bit 3 for counts 60 down to 1 (`blink`=1 at count 60, 0 at 55). Simultaneous `start`+`hit` → health 3, ALIVE.
- Assert `rst` asynchronously mid-INVULN, between clock edges → all outputs 0 before the next edge. After release, state is IDLE.
